// File: rtl/keypad_encoder_pkg.sv
// Shared definitions for the gencon keypad front-end: scan states, operator
// one-hot codes, key codes and small decode helpers.
package gencon_defs;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} keypad_state_t;
   typedef enum logic [1:0] {EMIT_IDLE, EMIT_SETUP, EMIT_STROBE} emit_state_t;

   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_MULT = 3'b100;

   localparam logic [3:0] KEY_0    = 4'd0;
   localparam logic [3:0] KEY_1    = 4'd1;
   localparam logic [3:0] KEY_2    = 4'd2;
   localparam logic [3:0] KEY_3    = 4'd3;
   localparam logic [3:0] KEY_4    = 4'd4;
   localparam logic [3:0] KEY_5    = 4'd5;
   localparam logic [3:0] KEY_6    = 4'd6;
   localparam logic [3:0] KEY_7    = 4'd7;
   localparam logic [3:0] KEY_8    = 4'd8;
   localparam logic [3:0] KEY_9    = 4'd9;
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // True when exactly one line of an active-low 4-bit group is low.
   function automatic logic single_low(input logic [3:0] v);
      return $onehot(~v);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      case (v)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'h0:    return KEY_1;
         4'h1:    return KEY_2;
         4'h2:    return KEY_3;
         4'h3:    return KEY_A;
         4'h4:    return KEY_4;
         4'h5:    return KEY_5;
         4'h6:    return KEY_6;
         4'h7:    return KEY_B;
         4'h8:    return KEY_7;
         4'h9:    return KEY_8;
         4'hA:    return KEY_9;
         4'hB:    return KEY_C;
         4'hC:    return KEY_STAR;
         4'hD:    return KEY_0;
         4'hE:    return KEY_HASH;
         default: return KEY_D;
      endcase
   endfunction

endpackage

// File: rtl/keypad_encoder_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines; idles high.
module keypad_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner/debouncer that turns key presses into gencon digit
// strobes, a held operator one-hot and an equal request with complete handshake.
module keypad_encoder
   import gencon_defs::*;
#(
   parameter int unsigned SCAN_DIV     = 16,
   parameter int unsigned DEBOUNCE_CYC = 64
) (
   input  logic       clk,
   input  logic       RST,
   input  logic [3:0] col_n,
   input  logic       digit_ready,
   input  logic       complete,
   output logic [3:0] row_n,
   output logic [3:0] keypad_input,
   output logic       read_input,
   output logic [2:0] operator_input,
   output logic       equal_input
);

   localparam int unsigned DW = $clog2(SCAN_DIV + 1);
   localparam int unsigned BW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_MAX    = BW'(DEBOUNCE_CYC);

   logic [3:0]    col_s;
   keypad_state_t state, state_nxt;
   logic [3:0]    row_n_nxt;
   logic [DW-1:0] dwell_cnt, dwell_nxt;
   logic [BW-1:0] deb_cnt, deb_nxt, deb_inc;
   logic [3:0]    cap_col, cap_col_nxt;
   logic          key_ev;
   logic [3:0]    key_code;

   emit_state_t   emit_st;
   logic          pending;
   logic [3:0]    pend_code;

   keypad_sync u_sync (
      .clk (clk),
      .rst (RST),
      .d   (col_n),
      .q   (col_s)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state     <= SCAN;
         row_n     <= 4'b1110;
         dwell_cnt <= '0;
         deb_cnt   <= '0;
         cap_col   <= '1;
      end else begin
         state     <= state_nxt;
         row_n     <= row_n_nxt;
         dwell_cnt <= dwell_nxt;
         deb_cnt   <= deb_nxt;
         cap_col   <= cap_col_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      row_n_nxt   = row_n;
      dwell_nxt   = dwell_cnt;
      deb_nxt     = deb_cnt;
      cap_col_nxt = cap_col;
      key_ev      = 1'b0;
      key_code    = '0;
      deb_inc     = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + BW'(1);

      case (state)
         SCAN: begin
            if (dwell_cnt >= DWELL_LAST) begin
               dwell_nxt = '0;
               if (single_low(col_s)) begin
                  cap_col_nxt = col_s;
                  deb_nxt     = '0;
                  state_nxt   = DEBOUNCE;
               end else begin
                  row_n_nxt = {row_n[2:0], row_n[3]};
               end
            end else begin
               dwell_nxt = dwell_cnt + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (col_s != cap_col) begin
               state_nxt = SCAN;
               row_n_nxt = {row_n[2:0], row_n[3]};
               deb_nxt   = '0;
            end else if (deb_inc == DEB_MAX) begin
               key_ev    = 1'b1;
               key_code  = key_lookup(low_index(row_n), low_index(cap_col));
               state_nxt = RELEASE;
               deb_nxt   = '0;
            end else begin
               deb_nxt = deb_inc;
            end
         end
         RELEASE: begin
            if (col_s != 4'b1111) begin
               deb_nxt = '0;
            end else if (deb_inc == DEB_MAX) begin
               state_nxt = SCAN;
               row_n_nxt = 4'b1110;
               dwell_nxt = '0;
               deb_nxt   = '0;
            end else begin
               deb_nxt = deb_inc;
            end
         end
         default: begin
            state_nxt = SCAN;
            row_n_nxt = 4'b1110;
            dwell_nxt = '0;
            deb_nxt   = '0;
         end
      endcase
   end

   // A digit decoded while digit_ready is already high skips the pending
   // register so SETUP lands on the cycle right after the decode.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         emit_st        <= EMIT_IDLE;
         pending        <= 1'b0;
         pend_code      <= '0;
         keypad_input   <= '0;
         read_input     <= 1'b0;
         operator_input <= '0;
         equal_input    <= 1'b0;
      end else begin
         case (emit_st)
            EMIT_IDLE: begin
               if (pending && digit_ready) begin
                  emit_st      <= EMIT_SETUP;
                  keypad_input <= pend_code;
                  pending      <= 1'b0;
               end
            end
            EMIT_SETUP: begin
               emit_st    <= EMIT_STROBE;
               read_input <= 1'b1;
            end
            default: begin
               emit_st      <= EMIT_IDLE;
               read_input   <= 1'b0;
               keypad_input <= '0;
            end
         endcase

         if (equal_input && complete) begin
            equal_input    <= 1'b0;
            operator_input <= '0;
         end

         if (key_ev) begin
            case (key_code)
               KEY_A: if (!equal_input) operator_input <= OP_ADD;
               KEY_B: if (!equal_input) operator_input <= OP_SUB;
               KEY_C: if (!equal_input) operator_input <= OP_MULT;
               KEY_D: begin
                  if (operator_input != '0 && !equal_input && !pending && emit_st == EMIT_IDLE)
                     equal_input <= 1'b1;
               end
               KEY_STAR: begin
                  operator_input <= '0;
                  equal_input    <= 1'b0;
                  pending        <= 1'b0;
               end
               KEY_HASH: ;
               default: begin
                  if (!equal_input && !pending && emit_st == EMIT_IDLE) begin
                     if (digit_ready) begin
                        emit_st      <= EMIT_SETUP;
                        keypad_input <= key_code;
                     end else begin
                        pending   <= 1'b1;
                        pend_code <= key_code;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: a matrix model drives col_n from row_n,
// directed presses queue expected digits, a monitor checks every strobe.
module tb_keypad_encoder;
   import gencon_defs::*;

   localparam int unsigned SD = 4;
   localparam int unsigned DC = 8;

   logic       clk = 1'b0;
   logic       RST;
   logic [3:0] col_n;
   logic       digit_ready;
   logic       complete;
   logic [3:0] row_n;
   logic [3:0] keypad_input;
   logic       read_input;
   logic [2:0] operator_input;
   logic       equal_input;

   logic [15:0] keys;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_q[$];
   int          op1, op2;
   bit          model_en = 1'b0;

   keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
      .clk            (clk),
      .RST            (RST),
      .col_n          (col_n),
      .digit_ready    (digit_ready),
      .complete       (complete),
      .row_n          (row_n),
      .keypad_input   (keypad_input),
      .read_input     (read_input),
      .operator_input (operator_input),
      .equal_input    (equal_input)
   );

   always #5 clk = ~clk;

   always_comb begin
      col_n = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [3:0] prev_kp;
   logic       prev_rd;
   bit         zero_due = 1'b0;
   logic [3:0] e;

   always @(negedge clk) begin
      if (!RST) begin
         if (zero_due) begin
            chk("kp_after_strobe", keypad_input, 0);
            zero_due = 1'b0;
         end
         if (read_input) begin
            chk("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("strobe_code", keypad_input, e);
               chk("setup_code", prev_kp, e);
               chk("setup_read_low", prev_rd, 0);
               zero_due = 1'b1;
               if (model_en) begin
                  if (operator_input == 3'b000) op1 = op1 * 10 + int'(keypad_input);
                  else                          op2 = op2 * 10 + int'(keypad_input);
               end
            end
         end
      end
      prev_kp = keypad_input;
      prev_rd = read_input;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int k, input int hold, input bit bounce);
      if (bounce) begin
         for (int i = 0; i < 10; i++) begin
            keys[k] = (i % 3 != 2);
            cycles(1);
         end
      end
      keys[k] = 1'b1;
      cycles(hold);
      keys[k] = 1'b0;
      cycles(40);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_row"}, row_n, 4'b1110);
      chk({tag, "_kp"}, keypad_input, 0);
      chk({tag, "_rd"}, read_input, 0);
      chk({tag, "_op"}, operator_input, 0);
      chk({tag, "_eq"}, equal_input, 0);
   endtask

   task automatic wait_row(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (row_n !== target && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, row_n, target);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      RST = 1'b1; keys = '0; digit_ready = 1'b1; complete = 1'b0;
      cycles(3);
      chk_reset("reset");
      @(posedge clk); #1 RST = 1'b0;

      // Bounced press of "1"
      exp_q.push_back(4'd1);
      press(0, 60, 1'b1);
      chk("q_after_1", exp_q.size(), 0);

      // 11 + 23 through a gencon model
      op1 = 0; op2 = 0; model_en = 1'b1;
      exp_q.push_back(4'd1); press(0, 60, 1'b0);
      exp_q.push_back(4'd1); press(0, 60, 1'b0);
      press(3, 60, 1'b0);
      chk("op_add", operator_input, 3'b001);
      exp_q.push_back(4'd2); press(1, 60, 1'b0);
      exp_q.push_back(4'd3); press(2, 60, 1'b0);
      press(15, 60, 1'b0);
      chk("eq_raised", equal_input, 1);
      @(posedge clk); #1 complete = 1'b1;
      @(negedge clk); chk("eq_during_complete", equal_input, 1);
      @(posedge clk); #1 complete = 1'b0;
      @(negedge clk);
      chk("eq_after_complete", equal_input, 0);
      chk("op_after_complete", operator_input, 3'b000);
      model_en = 1'b0;
      chk("model_result", op1 + op2, 34);
      chk("q_after_calc", exp_q.size(), 0);

      // 7 held pending while digit_ready low; 8 dropped
      @(posedge clk); #1 digit_ready = 1'b0;
      exp_q.push_back(4'd7);
      press(8, 50, 1'b0);
      press(9, 50, 1'b0);
      chk("pending_held", exp_q.size(), 1);
      @(posedge clk); #1 digit_ready = 1'b1;
      @(negedge clk); chk("rise_kp", keypad_input, 0); chk("rise_rd", read_input, 0);
      @(negedge clk); chk("setup7_kp", keypad_input, 4'd7); chk("setup7_rd", read_input, 0);
      @(negedge clk); chk("strobe7_rd", read_input, 1);
      cycles(3);
      chk("q_after_7", exp_q.size(), 0);

      // Operators, stray complete, clear, equal without operator
      press(3, 60, 1'b0);
      chk("op_a", operator_input, 3'b001);
      @(posedge clk); #1 complete = 1'b1;
      @(posedge clk); #1 complete = 1'b0;
      @(negedge clk);
      chk("stray_complete_op", operator_input, 3'b001);
      chk("stray_complete_eq", equal_input, 0);
      press(11, 60, 1'b0);
      chk("op_c", operator_input, 3'b100);
      press(12, 60, 1'b0);
      chk("op_cleared", operator_input, 3'b000);
      press(15, 60, 1'b0);
      chk("eq_no_op", equal_input, 0);

      // Long hold, then a two-column press in one row
      exp_q.push_back(4'd5);
      press(5, 1000, 1'b0);
      chk("q_after_hold", exp_q.size(), 0);
      keys[4] = 1'b1; keys[5] = 1'b1;
      cycles(100);
      keys[4] = 1'b0; keys[5] = 1'b0;
      cycles(40);
      chk("q_after_multi", exp_q.size(), 0);

      // Reset during DEBOUNCE of "9"
      wait_row(4'b1110, "wait_row0");
      keys[10] = 1'b1;
      wait_row(4'b1011, "wait_row2");
      cycles(5);
      #2 RST = 1'b1;
      #1 chk_reset("rst_deb");
      keys = '0;
      cycles(3);
      RST = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); chk("restart_row0", row_n, 4'b1110);
      @(posedge clk);
      @(negedge clk); chk("restart_row1", row_n, 4'b1101);

      // Reset during STROBE of "2"
      keys[1] = 1'b1;
      n = 0;
      @(negedge clk);
      while (keypad_input !== 4'd2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_setup2", keypad_input, 4'd2);
      @(posedge clk); #1;
      chk("in_strobe2", read_input, 1);
      #1 RST = 1'b1;
      #1 chk_reset("rst_strobe");
      keys = '0;
      cycles(3);
      RST = 1'b0;
      cycles(50);
      chk("q_final", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
